instruction_fetch: RTL and testbench

//   IF stage plus IF/ID pipeline register. Keeps the PC and fetches instructions

---
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
//-----------------------------------------------------------------------------
// instruction_fetch
//   IF stage plus IF/ID pipeline register. Holds the PC, fetches over a
//   req/gnt + rvalid memory interface with at most one request outstanding,
//   buffers one returned word in a skid entry while decode stalls, and
//   handles taken-branch redirects. Bubbles are presented as NOP_INSTR.
//
// Ports
//   clk, rst_n     clock (rising edge) / asynchronous active-low reset
//   imem_req       fetch request at imem_addr
//   imem_addr      fetch address (= pc), word aligned
//   imem_gnt       memory accepts the request this cycle
//   imem_rvalid    read data valid (in order, >= 1 cycle after gnt)
//   imem_rdata     instruction word
//   id_stall       decode cannot accept; IF/ID holds
//   redirect       taken branch/jump: flush and refetch from redirect_pc
//   redirect_pc    redirect target, bits [1:0] ignored
//   if_id_valid    IF/ID holds a real instruction
//   if_id_pc       PC of if_id_instr
//   if_id_instr    instruction to decode, NOP_INSTR when invalid
//   dbg_state_o    fetch FSM state (0=REQ, 1=WAIT, 2=DROP)
//
// Handshake: a request is transferred on a cycle where imem_req and imem_gnt
// are both high; imem_addr is held stable from the first imem_req cycle until
// that transfer. Exactly one rvalid pulse answers each transfer.
//-----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        id_stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_pc_q;      // address of the request in flight
   logic        skid_valid_q;
   logic [31:0] skid_pc_q;
   logic [31:0] skid_instr_q;
   logic        if_id_valid_q;
   logic [31:0] if_id_pc_q;
   logic [31:0] if_id_instr_q;

   logic req_fire;
   logic resp;
   logic advance;

   // A full skid blocks new requests, so the skid can never overflow.
   assign imem_req  = rst_n && (state_q == S_REQ) && !skid_valid_q && !redirect;
   assign imem_addr = pc_q;
   assign req_fire  = imem_req && imem_gnt;
   assign resp      = (state_q == S_WAIT) && imem_rvalid;
   assign advance   = !id_stall || !if_id_valid_q;

   assign pc_d = redirect ? (redirect_pc & ~32'd3) :
                 req_fire ? (pc_q + 32'd4) : pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         fetch_pc_q    <= 32'd0;
         skid_valid_q  <= 1'b0;
         skid_pc_q     <= 32'd0;
         skid_instr_q  <= 32'd0;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= 32'd0;
         if_id_instr_q <= NOP_INSTR;
      end else begin
         pc_q <= pc_d;
         if (redirect) begin
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            skid_valid_q  <= 1'b0;
            // An in-flight word is stale: drop it now or when it arrives.
            // A response landing in DROP during a redirect is that stale
            // word, so it is consumed here rather than waited for again.
            case (state_q)
               S_WAIT, S_DROP: state_q <= imem_rvalid ? S_REQ : S_DROP;
               default:        state_q <= S_REQ;
            endcase
         end else begin
            case (state_q)
               S_REQ: begin
                  if (req_fire) begin
                     state_q    <= S_WAIT;
                     fetch_pc_q <= pc_q;
                  end
               end
               S_WAIT:  if (imem_rvalid) state_q <= S_REQ;
               S_DROP:  if (imem_rvalid) state_q <= S_REQ;
               default: state_q <= S_REQ;
            endcase

            if (advance) begin
               if (skid_valid_q) begin
                  if_id_valid_q <= 1'b1;
                  if_id_pc_q    <= skid_pc_q;
                  if_id_instr_q <= skid_instr_q;
                  skid_valid_q  <= 1'b0;
               end else if (resp) begin
                  if_id_valid_q <= 1'b1;
                  if_id_pc_q    <= fetch_pc_q;
                  if_id_instr_q <= imem_rdata;
               end else begin
                  if_id_valid_q <= 1'b0;
                  if_id_instr_q <= NOP_INSTR;
               end
            end else if (resp) begin
               // Skid is always empty in WAIT because requests are gated on it.
               skid_valid_q <= 1'b1;
               skid_pc_q    <= fetch_pc_q;
               skid_instr_q <= imem_rdata;
            end
         end
      end
   end

   assign if_id_valid = if_id_valid_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] WRAP = 32'hFFFF_FFFC;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT 1 (RESET_PC = 0)
   logic        imem_req, imem_gnt, imem_rvalid, id_stall, redirect, if_id_valid;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, if_id_pc, if_id_instr;
   logic [1:0]  dbg_state;

   // DUT 2 (RESET_PC = 0xFFFFFFFC)
   logic        imem_req2, imem_gnt2, imem_rvalid2, id_stall2, redirect2, if_id_valid2;
   logic [31:0] imem_addr2, imem_rdata2, redirect_pc2, if_id_pc2, if_id_instr2;
   logic [1:0]  dbg_state2;

   instruction_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
      .dbg_state_o(dbg_state)
   );

   instruction_fetch #(.RESET_PC(WRAP)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
      .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
      .id_stall(id_stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
      .if_id_valid(if_id_valid2), .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2),
      .dbg_state_o(dbg_state2)
   );

   // scoreboard
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // memory contents: a fixed function of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hC3A5_0F03;
   endfunction

   // reference model: program order of delivered instructions and fetches
   logic [31:0] exp_pc, exp_fetch;
   int          consumed;
   // memory model
   bit          outst;
   int          dly_cnt, dmin, dmax, gnt_pct;
   logic [31:0] out_addr;
   bit          did_gnt;
   // cycle-to-cycle history
   bit          prev_hold, prev_req_wait;
   logic [31:0] hold_pc, hold_instr, wait_addr;
   // DUT 2 model
   bit          pend2;
   int          g2_cnt;

   task automatic model_reset();
      exp_pc = 32'h0; exp_fetch = 32'h0;
      outst = 0; dly_cnt = 0; did_gnt = 0;
      prev_hold = 0; prev_req_wait = 0;
      pend2 = 0; g2_cnt = 0;
   endtask

   task automatic do_reset(input bit mid);
      if (mid) begin
         @(posedge clk);
         #3;
      end
      rst_n = 1'b0;
      #1;
      check("rst_req",   {31'b0, imem_req}, 32'h0);
      check("rst_valid", {31'b0, if_id_valid}, 32'h0);
      check("rst_pc",    if_id_pc, 32'h0);
      check("rst_instr", if_id_instr, NOP);
      check("rst_req2",  {31'b0, imem_req2}, 32'h0);
      id_stall = 0; redirect = 0; redirect_pc = 0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
      imem_gnt2 = 0; imem_rvalid2 = 0;
      repeat (2) @(negedge clk);
      check("rst_addr",  imem_addr, 32'h0);
      check("rst_addr2", imem_addr2, WRAP);
      model_reset();
      rst_n = 1'b1;
   endtask

   // One clock cycle: check registered outputs, drive inputs, answer memory.
   task automatic step(input bit stall, input bit redir, input logic [31:0] tgt);
      @(negedge clk);
      if (prev_hold) begin
         check("stall_hold_valid", {31'b0, if_id_valid}, 32'h1);
         check("stall_hold_pc",    if_id_pc, hold_pc);
         check("stall_hold_instr", if_id_instr, hold_instr);
      end
      if (!if_id_valid) check("bubble_nop", if_id_instr, NOP);

      id_stall = stall; redirect = redir; redirect_pc = tgt; imem_gnt = 0;
      if (outst && dly_cnt == 0) begin
         imem_rvalid = 1; imem_rdata = mem_word(out_addr); outst = 0;
      end else begin
         imem_rvalid = 0; imem_rdata = $urandom;
         if (outst) dly_cnt--;
      end
      imem_rvalid2 = pend2; imem_gnt2 = 1; imem_rdata2 = $urandom;
      #1;

      if (redir) check("no_req_on_redirect", {31'b0, imem_req}, 32'h0);
      if (prev_req_wait && !redir) begin
         check("req_held",  {31'b0, imem_req}, 32'h1);
         check("addr_held", imem_addr, wait_addr);
      end
      did_gnt = 0;
      if (imem_req && $urandom_range(99, 0) < gnt_pct) begin
         imem_gnt = 1; did_gnt = 1;
         check("one_outstanding", {31'b0, outst || imem_rvalid}, 32'h0);
         check("fetch_addr", imem_addr, exp_fetch);
         exp_fetch = exp_fetch + 32'd4;
         outst = 1; out_addr = imem_addr;
         dly_cnt = $urandom_range(dmax, dmin);
      end
      prev_req_wait = imem_req && !imem_gnt;
      wait_addr = imem_addr;

      if (redir) begin
         exp_fetch = tgt & ~32'd3;
         exp_pc    = tgt & ~32'd3;
      end else if (if_id_valid && !stall) begin
         check("deliver_pc",    if_id_pc, exp_pc);
         check("deliver_instr", if_id_instr, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         consumed++;
      end
      prev_hold  = stall && if_id_valid && !redir;
      hold_pc    = if_id_pc;
      hold_instr = if_id_instr;

      pend2 = imem_req2;
      if (imem_req2) begin
         g2_cnt++;
         if (g2_cnt == 1)      check("wrap_first",  imem_addr2, WRAP);
         else if (g2_cnt == 2) check("wrap_second", imem_addr2, 32'h0);
      end
   endtask

   initial begin
      int n;
      consumed = 0;
      id_stall2 = 0; redirect2 = 0; redirect_pc2 = 0;
      rst_n = 1'b1;
      model_reset();
      #2;
      do_reset(0);

      // zero-wait memory, then a 4-cycle stall with pc 4 in IF/ID
      gnt_pct = 100; dmin = 0; dmax = 0;
      repeat (4) step(0, 0, 32'h0);
      step(1, 0, 32'h0);
      step(1, 0, 32'h0);
      step(1, 0, 32'h0);
      check("no_req_skid_full", {31'b0, imem_req}, 32'h0);
      step(1, 0, 32'h0);
      check("no_req_skid_full", {31'b0, imem_req}, 32'h0);
      step(0, 0, 32'h0);
      step(0, 0, 32'h0);
      check("skid_to_ifid", if_id_pc, 32'h8);
      repeat (8) step(0, 0, 32'h0);

      // redirect while waiting, response two cycles later
      dmin = 2; dmax = 2;
      n = 0;
      do begin step(0, 0, 32'h0); n++; end while (!did_gnt && n < 10);
      check("t3_got_grant", {31'b0, did_gnt}, 32'h1);
      step(0, 1, 32'h100);
      step(0, 0, 32'h0);
      check("t3_flush_valid", {31'b0, if_id_valid}, 32'h0);
      check("t3_flush_instr", if_id_instr, NOP);
      repeat (14) step(0, 0, 32'h0);

      // redirect to unaligned target while request is pending ungranted
      gnt_pct = 0; dmin = 0; dmax = 0;
      n = 0;
      do begin step(0, 0, 32'h0); n++; end while (!imem_req && n < 10);
      check("t4_req_pending", {31'b0, imem_req}, 32'h1);
      step(0, 1, 32'h203);
      gnt_pct = 100;
      repeat (10) step(0, 0, 32'h0);

      // asynchronous reset in the middle of a wait
      dmin = 3; dmax = 3;
      n = 0;
      do begin step(0, 0, 32'h0); n++; end while (!did_gnt && n < 10);
      check("t5_got_grant", {31'b0, did_gnt}, 32'h1);
      step(0, 0, 32'h0);
      do_reset(1);
      dmin = 0; dmax = 0;
      repeat (10) step(0, 0, 32'h0);

      // randomized traffic
      gnt_pct = 70; dmin = 0; dmax = 3;
      for (int i = 0; i < 2000; i++) begin
         bit s, r;
         logic [31:0] t;
         s = ($urandom_range(99, 0) < 30);
         r = ($urandom_range(99, 0) < 5);
         t = $urandom & 32'h0000_0FFF;
         if (i % 16 == 0) t = WRAP;
         step(s, r, t);
      end
      check("progress", {31'b0, consumed > 150}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
